register_loader: RTL and testbench

Sequencer that writes a bank of `NUM_REGS` parameter registers, such as the 3x3 kernel weights of a convolution stage, from a single valid/ready word stream. It is the driving end of the register load interface: a shared data bus plus one active-low load strobe per register. On a start pulse it accepts exactly `NUM_REGS` words and writes word *i* into register *i* through a one-cycle low strobe. It then pulses done.

---
 rtl/register_loader.sv | 102 ++++++++++
 tb/tb_register_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/register_loader.sv
// Register-bank loader: accepts NUM_REGS words on a valid/ready stream and writes word i to
// register i through a one-cycle active-low strobe. Optional abort input: REGISTER_LOADER_ABORT_EN.
module register_loader #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned NUM_REGS      = 9,
  parameter int unsigned CNT_WIDTH     = 4
) (
  input  logic                     register_loader_CLOCK,
  input  logic                     register_loader_Reset_InHigh,
  input  logic                     register_loader_Start_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] register_loader_DataInBUS,
  input  logic                     register_loader_DataInValid,
`ifdef REGISTER_LOADER_ABORT_EN
  input  logic                     register_loader_Abort_InHigh,
`endif
  output logic                     register_loader_DataInReady,
  output logic [DATAWIDTH_BUS-1:0] register_loader_DataOutBUS,
  output logic [NUM_REGS-1:0]      register_loader_Load_InLow,
  output logic                     register_loader_Busy,
  output logic                     register_loader_Done
);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(NUM_REGS - 1);

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     index_q, index_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [NUM_REGS-1:0]      load_q, load_d;
  logic                     abort;

`ifdef REGISTER_LOADER_ABORT_EN
  assign abort = register_loader_Abort_InHigh;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge register_loader_CLOCK or posedge register_loader_Reset_InHigh) begin
    if (register_loader_Reset_InHigh) begin
      state_q <= StIdle;
      index_q <= '0;
      data_q  <= '0;
      load_q  <= '1;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    load_d  = load_q;
    unique case (state_q)
      StIdle: begin
        if (register_loader_Start_InHigh) begin
          index_d = '0;
          state_d = StAccept;
        end
      end
      StAccept: begin
        // Abort wins over a word arriving in the same cycle.
        if (abort) begin
          load_d  = '1;
          state_d = StIdle;
        end else if (register_loader_DataInValid) begin
          data_d  = register_loader_DataInBUS;
          load_d  = ~(NUM_REGS'(1) << index_q);
          state_d = StWrite;
        end
      end
      StWrite: begin
        load_d = '1;
        if (abort) begin
          state_d = StIdle;
        end else if (index_q == LastIdx) begin
          state_d = StDone;
        end else begin
          index_d = index_q + 1'b1;
          state_d = StAccept;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign register_loader_DataInReady = (state_q == StAccept);
  assign register_loader_Busy        = (state_q == StAccept) || (state_q == StWrite);
  assign register_loader_Done        = (state_q == StDone);
  assign register_loader_DataOutBUS  = data_q;
  assign register_loader_Load_InLow  = load_q;

endmodule

// File: tb/tb_register_loader.sv
// Directed bench for register_loader with NUM_REGS=9, 8-bit words 8'h11..8'h99.
module tb_register_loader;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   din = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic [7:0]   dout;
  logic [N-1:0] load;
  logic         busy;
  logic         done;
`ifdef REGISTER_LOADER_ABORT_EN
  logic         abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  register_loader #(
    .DATAWIDTH_BUS(8),
    .NUM_REGS(N),
    .CNT_WIDTH(4)
  ) dut (
    .register_loader_CLOCK(clk),
    .register_loader_Reset_InHigh(rst),
    .register_loader_Start_InHigh(start),
    .register_loader_DataInBUS(din),
    .register_loader_DataInValid(valid),
`ifdef REGISTER_LOADER_ABORT_EN
    .register_loader_Abort_InHigh(abort),
`endif
    .register_loader_DataInReady(ready),
    .register_loader_DataOutBUS(dout),
    .register_loader_Load_InLow(load),
    .register_loader_Busy(busy),
    .register_loader_Done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] wd(input int i);
    return 8'((i + 1) * 17);
  endfunction

  function automatic logic [N-1:0] strobe(input int i);
    logic [N-1:0] one;
    one = N'(1);
    return ~(one << i);
  endfunction

  task automatic start_seq();
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    chk("accept_ready", 32'(ready), 32'd1);
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  // One word: optional Valid-low gap, accept edge, then write edge.
  task automatic do_word(input int i, input int gap, input bit st);
    valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      step();
      chk("gap_ready", 32'(ready), 32'd1);
      chk("gap_no_strobe", 32'(load), 32'(N'('1)));
    end
    valid = 1'b1;
    din   = wd(i);
    start = st;
    step();
    chk("strobe_bus", 32'(dout), 32'(wd(i)));
    chk("strobe_bit", 32'(load), 32'(strobe(i)));
    chk("write_ready", 32'(ready), 32'd0);
    chk("write_busy", 32'(busy), 32'd1);
    din = 8'h00;
    step();
    start = 1'b0;
    chk("strobe_release", 32'(load), 32'(N'('1)));
    if (i < N - 1) begin
      chk("next_ready", 32'(ready), 32'd1);
      chk("next_done", 32'(done), 32'd0);
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_ready", 32'(ready), 32'd0);
    end
  endtask

  initial begin
    // Reset asserted mid-cycle, checked before any edge.
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("rst_bus", 32'(dout), 32'd0);
    chk("rst_load", 32'(load), 32'h1FF);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(ready), 32'd0);

    // Full sequence with Valid held high; Start during DONE ignored.
    start_seq();
    for (int i = 0; i < N; i++) do_word(i, 0, 1'b0);
    chk("done_edge", 32'(cyc - c0), 32'd18);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_once", 32'(done), 32'd0);
    chk("start_in_done_ignored", 32'(ready), 32'd0);
    chk("hold_bus", 32'(dout), 32'h99);
    step();
    chk("still_idle", 32'(busy), 32'd0);

    // Backpressure before word 4, stray Start during word 5.
    start_seq();
    for (int i = 0; i < N; i++) do_word(i, (i == 4) ? 3 : 0, i == 5);
    chk("done_edge_gap", 32'(cyc - c0), 32'd21);
    valid = 1'b0;
    step();
    chk("gap_seq_idle", 32'(ready), 32'd0);
    chk("gap_seq_done_once", 32'(done), 32'd0);

    // Start and Valid together in IDLE: no word taken at that edge.
    valid = 1'b1;
    din   = 8'hAA;
    start = 1'b1;
    #1;
    chk("idle_sv_ready", 32'(ready), 32'd0);
    step();
    start = 1'b0;
    chk("idle_sv_no_strobe", 32'(load), 32'h1FF);
    chk("idle_sv_bus", 32'(dout), 32'h99);
    chk("idle_sv_accept", 32'(ready), 32'd1);

    // Reset during WRITE of word 2, then a fresh sequence.
    do_word(0, 0, 1'b0);
    do_word(1, 0, 1'b0);
    valid = 1'b1;
    din   = wd(2);
    step();
    chk("w2_strobe", 32'(load), 32'h1FB);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_load", 32'(load), 32'h1FF);
    chk("midrst_bus", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(ready), 32'd0);
    start_seq();
    for (int i = 0; i < N; i++) do_word(i, 0, 1'b0);
    chk("restart_done_edge", 32'(cyc - c0), 32'd18);
    valid = 1'b0;
    step();

`ifdef REGISTER_LOADER_ABORT_EN
    // Abort in ACCEPT of word 6, with a valid word present.
    start_seq();
    for (int i = 0; i < 6; i++) do_word(i, 0, 1'b0);
    valid = 1'b1;
    din   = wd(6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    valid = 1'b0;
    chk("abort_load", 32'(load), 32'h1FF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bus", 32'(dout), 32'h66);
    step();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
